alu_issue_stage: RTL and testbench

Pipeline stage directly upstream of the ALU: accepts a decoded instruction's operands and control fields, and produces the ALU's `a`, `b` and 4-bit `ctl` inputs one cycle later. It covers ALU-control decode, immediate sign-extension and operand selection, and the optional EX/MEM and MEM/WB forwarding. It uses a valid/ready handshake with stall and flush, so the ALU always sees stable, registered operands.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_issue_stage_if.sv | 45 ++++
 rtl/alu_ctl_decode.sv | 37 +++
 rtl/alu_issue_stage.sv | 108 ++++++++++
 tb/tb_alu_issue_stage.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: ALU control codes,
// main-decoder ALU classes, R-type function codes and the output-register state.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned CTL_W     = 4;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned IMM_W     = 16;

    // ALU control codes driven on ctl
    localparam logic [CTL_W-1:0] ALU_AND = 4'd0;
    localparam logic [CTL_W-1:0] ALU_OR  = 4'd1;
    localparam logic [CTL_W-1:0] ALU_ADD = 4'd2;
    localparam logic [CTL_W-1:0] ALU_SUB = 4'd6;
    localparam logic [CTL_W-1:0] ALU_SLT = 4'd7;
    localparam logic [CTL_W-1:0] ALU_NOR = 4'd12;
    localparam logic [CTL_W-1:0] ALU_BAD = 4'd15;

    // Main-decoder ALU classes
    localparam logic [OP_W-1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [OP_W-1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [OP_W-1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [OP_W-1:0] ALU_OP_RSVD   = 2'b11;

    // R-type function codes
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'h27;

    // Decoder result
    typedef struct packed {
        logic             illegal;
        logic [CTL_W-1:0] ctl;
    } alu_dec_t;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: upstream instruction fields, forwarding candidates,
// flush, and the registered ALU-side outputs with their handshake.
interface alu_issue_stage_if #(
    parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [4:0]       rs_idx;
    logic [4:0]       rt_idx;
    logic [15:0]      imm;
    logic             alu_src;
    logic             exmem_wr;
    logic [4:0]       exmem_rd;
    logic [WIDTH-1:0] exmem_val;
    logic             memwb_wr;
    logic [4:0]       memwb_rd;
    logic [WIDTH-1:0] memwb_val;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctl;
    logic             illegal;

    // Driver side (decode stage / bench)
    modport master (
        output in_valid, alu_op, funct, rs_val, rt_val, rs_idx, rt_idx, imm, alu_src,
               exmem_wr, exmem_rd, exmem_val, memwb_wr, memwb_rd, memwb_val,
               flush, out_ready,
        input  in_ready, out_valid, a, b, ctl, illegal
    );

    // Issue stage side
    modport slave (
        input  in_valid, alu_op, funct, rs_val, rt_val, rs_idx, rt_idx, imm, alu_src,
               exmem_wr, exmem_rd, exmem_val, memwb_wr, memwb_rd, memwb_val,
               flush, out_ready,
        output in_ready, out_valid, a, b, ctl, illegal
    );
endinterface

// File: rtl/alu_ctl_decode.sv
// Combinational ALU-control decode: alu_op/funct -> 4-bit ctl plus illegal flag.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]    alu_op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [CTL_W-1:0]   ctl_c_o,
    output logic               illegal_c_o
);

    alu_dec_t dec_c;

    // Anything not explicitly decoded falls through to ALU_BAD / illegal
    always_comb begin
        dec_c = '{illegal: 1'b1, ctl: ALU_BAD};
        case (alu_op_i)
            ALU_OP_MEM:    dec_c = '{illegal: 1'b0, ctl: ALU_ADD};
            ALU_OP_BRANCH: dec_c = '{illegal: 1'b0, ctl: ALU_SUB};
            ALU_OP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: dec_c = '{illegal: 1'b0, ctl: ALU_ADD};
                    FUNCT_SUB: dec_c = '{illegal: 1'b0, ctl: ALU_SUB};
                    FUNCT_AND: dec_c = '{illegal: 1'b0, ctl: ALU_AND};
                    FUNCT_OR:  dec_c = '{illegal: 1'b0, ctl: ALU_OR};
                    FUNCT_SLT: dec_c = '{illegal: 1'b0, ctl: ALU_SLT};
                    FUNCT_NOR: dec_c = '{illegal: 1'b0, ctl: ALU_NOR};
                    default:   dec_c = '{illegal: 1'b1, ctl: ALU_BAD};
                endcase
            end
            default:       dec_c = '{illegal: 1'b1, ctl: ALU_BAD};
        endcase
    end

    assign ctl_c_o     = dec_c.ctl;
    assign illegal_c_o = dec_c.illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALU control, selects (optionally forwarded) operands
// and holds them in a one-entry output register with valid/ready, stall and flush.
// Build option: define ALU_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input logic               clk,
    input logic               rst,
    alu_issue_stage_if.slave  issue_io
);

    issue_state_e     state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CTL_W-1:0] ctl_q;
    logic             illegal_q;

    logic [WIDTH-1:0] a_d, b_d;
    logic [WIDTH-1:0] rs_fwd_c, rt_fwd_c, imm_ext_c;
    logic [CTL_W-1:0] ctl_c;
    logic             illegal_c;
    logic             in_ready_c;
    logic             accept_c;

    alu_ctl_decode u_ctl_decode (
        .alu_op_i    (issue_io.alu_op),
        .funct_i     (issue_io.funct),
        .ctl_c_o     (ctl_c),
        .illegal_c_o (illegal_c)
    );

`ifdef ALU_FWD_EN
    // Youngest producer wins; register 0 is hard-wired and never forwarded
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [IDX_W-1:0] idx,
        input logic [WIDTH-1:0] rf_val,
        input logic             ex_wr,
        input logic [IDX_W-1:0] ex_rd,
        input logic [WIDTH-1:0] ex_val,
        input logic             wb_wr,
        input logic [IDX_W-1:0] wb_rd,
        input logic [WIDTH-1:0] wb_val
    );
        if (ex_wr && (ex_rd == idx) && (idx != '0)) return ex_val;
        if (wb_wr && (wb_rd == idx) && (idx != '0)) return wb_val;
        return rf_val;
    endfunction

    // Forwarding muxes for both source operands
    always_comb begin
        rs_fwd_c = fwd_sel(issue_io.rs_idx, issue_io.rs_val,
                           issue_io.exmem_wr, issue_io.exmem_rd, issue_io.exmem_val,
                           issue_io.memwb_wr, issue_io.memwb_rd, issue_io.memwb_val);
        rt_fwd_c = fwd_sel(issue_io.rt_idx, issue_io.rt_val,
                           issue_io.exmem_wr, issue_io.exmem_rd, issue_io.exmem_val,
                           issue_io.memwb_wr, issue_io.memwb_rd, issue_io.memwb_val);
    end
`else
    // Without forwarding the register-file values go straight through
    assign rs_fwd_c = issue_io.rs_val;
    assign rt_fwd_c = issue_io.rt_val;

    logic unused_fwd;
    assign unused_fwd = ^{issue_io.exmem_wr, issue_io.exmem_rd, issue_io.exmem_val,
                          issue_io.memwb_wr, issue_io.memwb_rd, issue_io.memwb_val,
                          issue_io.rs_idx, issue_io.rt_idx};
`endif

    // Operand selection with immediate sign-extension to the datapath width
    always_comb begin
        imm_ext_c = WIDTH'($signed(issue_io.imm));
        a_d       = rs_fwd_c;
        b_d       = issue_io.alu_src ? imm_ext_c : rt_fwd_c;
    end

    assign in_ready_c = (state_q == ST_EMPTY) || issue_io.out_ready;
    assign accept_c   = issue_io.in_valid && in_ready_c && !issue_io.flush;

    // Output register: reset beats flush, flush beats accept, drain when consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            a_q       <= '0;
            b_q       <= '0;
            ctl_q     <= '0;
            illegal_q <= 1'b0;
        end else if (issue_io.flush) begin
            state_q   <= ST_EMPTY;
        end else if (accept_c) begin
            state_q   <= ST_FULL;
            a_q       <= a_d;
            b_q       <= b_d;
            ctl_q     <= ctl_c;
            illegal_q <= illegal_c;
        end else if (issue_io.out_ready) begin
            state_q   <= ST_EMPTY;
        end
    end

    assign issue_io.in_ready  = in_ready_c;
    assign issue_io.out_valid = (state_q == ST_FULL);
    assign issue_io.a         = a_q;
    assign issue_io.b         = b_q;
    assign issue_io.ctl       = ctl_q;
    assign issue_io.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_alu_issue_stage;

`ifdef ALU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;

    alu_issue_stage_if #(.WIDTH(32)) bus ();

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .issue_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the output register contents
    bit          m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_ctl;
    logic        m_ill;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid  = 1'b0;
        bus.alu_op    = 2'd0;
        bus.funct     = 6'd0;
        bus.rs_val    = 32'd0;
        bus.rt_val    = 32'd0;
        bus.rs_idx    = 5'd0;
        bus.rt_idx    = 5'd0;
        bus.imm       = 16'd0;
        bus.alu_src   = 1'b0;
        bus.exmem_wr  = 1'b0;
        bus.exmem_rd  = 5'd0;
        bus.exmem_val = 32'd0;
        bus.memwb_wr  = 1'b0;
        bus.memwb_rd  = 5'd0;
        bus.memwb_val = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic load_instr(input logic [1:0] op, input logic [5:0] fn,
                              input logic [31:0] rsv, input logic [31:0] rtv,
                              input logic [4:0] rsi, input logic [4:0] rti,
                              input logic [15:0] im, input logic src);
        bus.alu_op  = op;
        bus.funct   = fn;
        bus.rs_val  = rsv;
        bus.rt_val  = rtv;
        bus.rs_idx  = rsi;
        bus.rt_idx  = rti;
        bus.imm     = im;
        bus.alu_src = src;
    endtask

    // {illegal, ctl} from the decode table
    function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return {1'b0, 4'd2};
        if (op == 2'd1) return {1'b0, 4'd6};
        if (op == 2'd2) begin
            if (fn == 6'h20) return {1'b0, 4'd2};
            if (fn == 6'h22) return {1'b0, 4'd6};
            if (fn == 6'h24) return {1'b0, 4'd0};
            if (fn == 6'h25) return {1'b0, 4'd1};
            if (fn == 6'h2A) return {1'b0, 4'd7};
            if (fn == 6'h27) return {1'b0, 4'd12};
        end
        return {1'b1, 4'd15};
    endfunction

    function automatic logic [31:0] ref_src(input logic [4:0] idx, input logic [31:0] rf);
        if (FWD && idx != 0) begin
            if (bus.exmem_wr && bus.exmem_rd == idx) return bus.exmem_val;
            if (bus.memwb_wr && bus.memwb_rd == idx) return bus.memwb_val;
        end
        return rf;
    endfunction

    // Advance the model by one clock using the inputs currently driven
    function automatic void model_step();
        logic [4:0] d;
        bit take;
        if (rst) begin
            m_valid = 0; m_a = 0; m_b = 0; m_ctl = 0; m_ill = 0;
            return;
        end
        take = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
        if (take) begin
            d       = ref_decode(bus.alu_op, bus.funct);
            m_valid = 1;
            m_a     = ref_src(bus.rs_idx, bus.rs_val);
            m_b     = bus.alu_src ? {{16{bus.imm[15]}}, bus.imm} : ref_src(bus.rt_idx, bus.rt_val);
            m_ctl   = d[3:0];
            m_ill   = d[4];
        end else if (bus.flush || bus.out_ready) begin
            m_valid = 0;
        end
    endfunction

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        load_instr(2'd2, 6'h25, 32'h1234, 32'h5678, 5'd1, 5'd2, 16'd0, 1'b0);
        tick();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        n_checks++;
        if ({bus.a, bus.b, bus.ctl, bus.illegal} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got a=%h b=%h ctl=%0d ill=%b exp all zero",
                     bus.a, bus.b, bus.ctl, bus.illegal);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_rtype_or();
        set_idle();
        bus.out_ready = 1'b1;
        load_instr(2'd2, 6'h25, 32'hF0, 32'h0F, 5'd1, 5'd2, 16'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.a, bus.b, bus.ctl, bus.illegal} !== {1'b1, 32'hF0, 32'h0F, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL rtype_or got v=%b a=%h b=%h ctl=%0d ill=%b exp v=1 a=f0 b=0f ctl=1 ill=0",
                     bus.out_valid, bus.a, bus.b, bus.ctl, bus.illegal);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rtype_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_imm_back_to_back();
        set_idle();
        bus.out_ready = 1'b1;
        load_instr(2'd0, 6'h00, 32'h1234, 32'h5555, 5'd3, 5'd4, 16'hFFFC, 1'b1);
        bus.in_valid = 1'b1;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.a, bus.b, bus.ctl} !== {1'b1, 32'h1234, 32'hFFFFFFFC, 4'd2}) begin
            n_fail++;
            $display("FAIL imm_neg got v=%b a=%h b=%h ctl=%0d exp v=1 a=1234 b=fffffffc ctl=2",
                     bus.out_valid, bus.a, bus.b, bus.ctl);
        end
        load_instr(2'd1, 6'h00, 32'h9, 32'h5555, 5'd3, 5'd4, 16'h7FFF, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.a, bus.b, bus.ctl} !== {1'b1, 32'h9, 32'h00007FFF, 4'd6}) begin
            n_fail++;
            $display("FAIL imm_pos_b2b got v=%b a=%h b=%h ctl=%0d exp v=1 a=9 b=7fff ctl=6",
                     bus.out_valid, bus.a, bus.b, bus.ctl);
        end
        tick();
    endtask

    task automatic test_forwarding();
        set_idle();
        bus.out_ready = 1'b1;
        bus.exmem_wr = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_val = 32'h11;
        bus.memwb_wr = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_val = 32'h22;
        load_instr(2'd2, 6'h20, 32'h99, 32'h77, 5'd5, 5'd5, 16'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        n_checks++;
        if ({bus.a, bus.b} !== {(FWD ? 32'h11 : 32'h99), (FWD ? 32'h11 : 32'h77)}) begin
            n_fail++;
            $display("FAIL fwd_exmem_prio got a=%h b=%h exp a=%h b=%h", bus.a, bus.b,
                     FWD ? 32'h11 : 32'h99, FWD ? 32'h11 : 32'h77);
        end
        bus.exmem_rd = 5'd6;
        tick();
        n_checks++;
        if ({bus.a, bus.b} !== {(FWD ? 32'h22 : 32'h99), (FWD ? 32'h22 : 32'h77)}) begin
            n_fail++;
            $display("FAIL fwd_memwb got a=%h b=%h exp a=%h b=%h", bus.a, bus.b,
                     FWD ? 32'h22 : 32'h99, FWD ? 32'h22 : 32'h77);
        end
        bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
        load_instr(2'd2, 6'h20, 32'h99, 32'h77, 5'd0, 5'd0, 16'd0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.a, bus.b} !== {32'h99, 32'h77}) begin
            n_fail++; $display("FAIL fwd_reg0 got a=%h b=%h exp a=99 b=77", bus.a, bus.b);
        end
        tick();
    endtask

    task automatic test_stall();
        set_idle();
        bus.out_ready = 1'b1;
        load_instr(2'd2, 6'h24, 32'hA1, 32'hA2, 5'd1, 5'd2, 16'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        load_instr(2'd2, 6'h2A, 32'hB1, 32'hB2, 5'd3, 5'd4, 16'd0, 1'b0);
        bus.exmem_wr = 1'b1; bus.exmem_rd = 5'd1; bus.exmem_val = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready);
            end
            tick();
            n_checks++;
            if ({bus.out_valid, bus.a, bus.b, bus.ctl} !== {1'b1, 32'hA1, 32'hA2, 4'd0}) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got v=%b a=%h b=%h ctl=%0d exp v=1 a=a1 b=a2 ctl=0",
                         i, bus.out_valid, bus.a, bus.b, bus.ctl);
            end
        end
        bus.exmem_wr = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.a, bus.b, bus.ctl} !== {1'b1, 32'hB1, 32'hB2, 4'd7}) begin
            n_fail++;
            $display("FAIL stall_second got v=%b a=%h b=%h ctl=%0d exp v=1 a=b1 b=b2 ctl=7",
                     bus.out_valid, bus.a, bus.b, bus.ctl);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_illegal();
        set_idle();
        bus.out_ready = 1'b1;
        load_instr(2'd2, 6'h3F, 32'h3, 32'h4, 5'd1, 5'd2, 16'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.a, bus.ctl, bus.illegal} !== {1'b1, 32'h3, 4'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_funct got v=%b a=%h ctl=%0d ill=%b exp v=1 a=3 ctl=15 ill=1",
                     bus.out_valid, bus.a, bus.ctl, bus.illegal);
        end
        load_instr(2'd3, 6'h20, 32'h5, 32'h6, 5'd1, 5'd2, 16'd0, 1'b0);
        tick();
        n_checks++;
        if ({bus.ctl, bus.illegal} !== {4'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_op11 got ctl=%0d ill=%b exp ctl=15 ill=1", bus.ctl, bus.illegal);
        end
        load_instr(2'd2, 6'h27, 32'h5, 32'h6, 5'd1, 5'd2, 16'd0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.ctl, bus.illegal} !== {4'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL nor_decode got ctl=%0d ill=%b exp ctl=12 ill=0", bus.ctl, bus.illegal);
        end
        tick();
    endtask

    task automatic test_flush();
        set_idle();
        bus.out_ready = 1'b1;
        load_instr(2'd0, 6'h00, 32'hA, 32'hB, 5'd1, 5'd2, 16'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        load_instr(2'd0, 6'h00, 32'hBEEF, 32'hB, 5'd1, 5'd2, 16'd0, 1'b0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_full got v=%b exp=0", bus.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_dropped cyc=%0d got v=%b a=%h exp v=0", i, bus.out_valid, bus.a);
            end
        end
        // flush together with out_ready: held one consumed, incoming dropped
        load_instr(2'd0, 6'h00, 32'hC, 32'hD, 5'd1, 5'd2, 16'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.flush = 1'b1;
        load_instr(2'd0, 6'h00, 32'hDEAD, 32'hD, 5'd1, 5'd2, 16'd0, 1'b0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_with_ready got v=%b exp=0", bus.out_valid);
        end
        // reset while stalled discards the held instruction
        load_instr(2'd0, 6'h00, 32'h77, 32'h1, 5'd1, 5'd2, 16'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.a} !== {1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_midstall got v=%b rdy=%b a=%h exp v=0 rdy=1 a=0",
                     bus.out_valid, bus.in_ready, bus.a);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] fn_tab [6];
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        set_idle();
        rst = 1'b1;
        model_step();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.alu_op    = 2'($urandom_range(0, 3));
            bus.funct     = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 5)] : 6'($urandom);
            bus.rs_val    = $urandom;
            bus.rt_val    = $urandom;
            bus.rs_idx    = 5'($urandom_range(0, 7));
            bus.rt_idx    = 5'($urandom_range(0, 7));
            bus.imm       = 16'($urandom);
            bus.alu_src   = 1'($urandom);
            bus.exmem_wr  = 1'($urandom);
            bus.exmem_rd  = 5'($urandom_range(0, 7));
            bus.exmem_val = $urandom;
            bus.memwb_wr  = 1'($urandom);
            bus.memwb_rd  = 5'($urandom_range(0, 7));
            bus.memwb_val = $urandom;
            #1;
            n_checks++;
            if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, bus.in_ready, !m_valid || bus.out_ready);
            end
            model_step();
            tick();
            n_checks++;
            if (bus.out_valid !== m_valid) begin
                n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", i, bus.out_valid, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if ({bus.a, bus.b, bus.ctl, bus.illegal} !== {m_a, m_b, m_ctl, m_ill}) begin
                    n_fail++;
                    $display("FAIL rand_data cyc=%0d got a=%h b=%h ctl=%0d ill=%b exp a=%h b=%h ctl=%0d ill=%b",
                             i, bus.a, bus.b, bus.ctl, bus.illegal, m_a, m_b, m_ctl, m_ill);
                end
            end
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_rtype_or();
        test_imm_back_to_back();
        test_forwarding();
        test_stall();
        test_illegal();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
